// File: rtl/queue_pkg.sv
// Shared helpers for the parametrised ready/valid queue.
package queue_pkg;

  localparam int Q_PIPE = 1;
  localparam int Q_FLOW = 1;

  typedef logic [31:0] count_t;

  // Ceiling log2, never below 1 so a 1-entry pointer still has a bit.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/queue_ptr.sv
// Wrapping queue pointer: counts 0..DEPTH-1 with explicit wrap.
module queue_ptr
  import queue_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  logic at_end;

  assign at_end = (ptr == PW'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (clear)
      ptr <= '0;
    else if (inc)
      ptr <= at_end ? '0 : ptr + PW'(1);
  end

endmodule

// File: rtl/param_queue.sv
// Parametrised ready/valid FIFO with optional PIPE/FLOW modes.
// Define QUEUE_FLUSH_EN to add the io_flush input.
module param_queue
  import queue_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 2,
  parameter  int PIPE   = 0,
  parameter  int FLOW   = 0,
  localparam int CW     = clog2(DEPTH + 1),
  localparam int PW     = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              io_enq_ready,
  input  logic              io_enq_valid,
  input  logic [DATA_W-1:0] io_enq_bits,
  input  logic              io_deq_ready,
  output logic              io_deq_valid,
  output logic [DATA_W-1:0] io_deq_bits,
  output logic [CW-1:0]     io_count
`ifdef QUEUE_FLUSH_EN
  ,
  input  logic              io_flush
`endif
);

  localparam bit PIPE_ON = (PIPE == Q_PIPE);
  localparam bit FLOW_ON = (FLOW == Q_FLOW);

  logic [DATA_W-1:0] ram [DEPTH];
  logic [PW-1:0]     enq_ptr;
  logic [PW-1:0]     deq_ptr;
  logic              maybe_full;
  logic              ptr_match;
  logic              empty;
  logic              full;
  logic              do_enq;
  logic              do_deq;
  logic              bypass;
  logic              enq_fire;
  logic              deq_fire;
  logic              flush;
  logic              clear;
  count_t            e_w;
  count_t            d_w;
  count_t            cnt;

`ifdef QUEUE_FLUSH_EN
  assign flush = io_flush;
`else
  assign flush = 1'b0;
`endif

  assign clear     = reset | flush;
  assign ptr_match = (enq_ptr == deq_ptr);
  assign empty     = ptr_match & ~maybe_full;
  assign full      = ptr_match & maybe_full;

  assign io_enq_ready = ~full | (PIPE_ON & io_deq_ready);
  assign io_deq_valid = ~empty | (FLOW_ON & io_enq_valid);
  assign io_deq_bits  = (FLOW_ON && empty) ? io_enq_bits
                                           : ram[deq_ptr];

  assign do_enq = io_enq_ready & io_enq_valid;
  assign do_deq = io_deq_ready & io_deq_valid;

  // A flow-through transfer never touches storage.
  assign bypass   = FLOW_ON & empty & do_enq & do_deq;
  assign enq_fire = do_enq & ~bypass;
  assign deq_fire = do_deq & ~bypass;

  always_ff @(posedge clk) begin
    if (enq_fire && !clear)
      ram[enq_ptr] <= io_enq_bits;
  end

  always_ff @(posedge clk) begin
    if (clear)
      maybe_full <= 1'b0;
    else if (enq_fire != deq_fire)
      maybe_full <= enq_fire;
  end

  queue_ptr #(.DEPTH(DEPTH)) u_enq_ptr (
    .clk   (clk),
    .clear (clear),
    .inc   (enq_fire),
    .ptr   (enq_ptr)
  );

  queue_ptr #(.DEPTH(DEPTH)) u_deq_ptr (
    .clk   (clk),
    .clear (clear),
    .inc   (deq_fire),
    .ptr   (deq_ptr)
  );

  always_comb begin
    e_w = count_t'(enq_ptr);
    d_w = count_t'(deq_ptr);
    if (full)
      cnt = count_t'(DEPTH);
    else if (e_w >= d_w)
      cnt = e_w - d_w;
    else
      cnt = e_w + count_t'(DEPTH) - d_w;
  end

  assign io_count = CW'(cnt);

endmodule
